// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready load/store port with a fixed response latency.
// Handles RISC-V B/H/W sizing, sign/zero extension, and alignment/range/funct3 checking.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready; a response
  // transfers on a rising edge with rsp_valid & rsp_ready. Payloads hold while valid is high.

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic          misaligned;
  logic          out_of_range;
  logic          bad_funct3;
  logic          acc_err;
  logic          fire;
  logic          do_write;
  logic [AW-1:0] widx;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic [31:0]   wword;
  logic [3:0]    wmask;

  always_comb begin
    widx         = addr_q[AW+1:2];
    word         = mem[widx];
    misaligned   = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    out_of_range = (addr_q >= ADDR_LIMIT);
    case (f3_q)
      3'b000, 3'b001, 3'b010: bad_funct3 = 1'b0;
      3'b100, 3'b101:         bad_funct3 = we_q;
      default:                bad_funct3 = 1'b1;
    endcase
    acc_err = misaligned || out_of_range || bad_funct3;

    // Selected lane(s) are shifted down to bit 0 before extension.
    shifted = word >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = shifted;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase

    wword = wdata_q << {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  wmask = 4'b0001 << addr_q[1:0];
      3'b001:  wmask = 4'b0011 << {addr_q[1], 1'b0};
      3'b010:  wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase

    fire     = (state == S_WAIT) && (cnt == 4'd0);
    do_write = fire && we_q && !acc_err;
  end

  // RAM is not reset; a write only happens on the executing edge of a live transaction.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_INIT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fire) begin
            rsp_err   <= acc_err;
            rsp_rdata <= (we_q || acc_err) ? 32'd0 : load_data;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;

endmodule
